// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - round-robin scheduler sharing one fixed-delay counter
//
// Purpose:
//   Arbitrates NREQ requesters round-robin onto a single external counter.
//   Issues a one-cycle ld pulse, watches dn, and returns a one-cycle done
//   pulse (qualified by fail) to the owner. Flags early and missing dn.
//
// Ports:
//   clk          in   1     clock, all state on posedge
//   rst_n        in   1     asynchronous active-low reset
//   req          in   NREQ  level request per requester, held until done
//   gnt          out  NREQ  one-hot owner of the counter, 0 when idle
//   done         out  NREQ  one-cycle completion pulse to owner
//   fail         out  1     qualifies done: delay not observed correctly
//   ld           out  1     load pulse to counter
//   dn           in   1     counter done output
//   busy         out  1     scheduler not idle
//   err_early    out  1     sticky: dn seen before DELAY+1
//   err_timeout  out  1     sticky: dn absent at DELAY+1+TO_MARGIN

module counter_sched #(
  parameter int NREQ      = 4,
  parameter int DELAY     = 91,
  parameter int TO_MARGIN = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            fail,
  output logic            ld,
  input  logic            dn,
  output logic            busy,
  output logic            err_early,
  output logic            err_timeout
);

  localparam int OW = $clog2(NREQ);
  localparam int KW = $clog2(DELAY + TO_MARGIN + 2);

  localparam logic [KW-1:0]   K_ONE        = KW'(1);
  localparam logic [KW-1:0]   K_LAST_EARLY = KW'(DELAY);
  localparam logic [KW-1:0]   K_TIMEOUT    = KW'(DELAY + 1 + TO_MARGIN);
  localparam logic [OW-1:0]   OWN_ONE      = OW'(1);
  localparam logic [OW-1:0]   OWN_MAX      = OW'(NREQ - 1);
  localparam logic [OW:0]     NREQ_W       = (OW+1)'(NREQ);
  localparam logic [NREQ-1:0] ONE_N        = NREQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [OW-1:0]   owner, owner_nx;
  logic [OW-1:0]   rr_ptr, rr_nx;
  logic [KW-1:0]   k, k_nx;
  logic [OW-1:0]   pick;
  logic            pick_vld;
  logic [OW:0]     sum;
  logic            fail_nx;
  logic            set_early;
  logic            set_timeout;

  // Round-robin pick: scan offsets from high to low so the last hit, which
  // wins, is the first requester at or above rr_ptr (wrapping).
  always_comb begin
    pick     = rr_ptr;
    pick_vld = 1'b0;
    sum      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (OW+1)'(i);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (req[sum[OW-1:0]]) begin
        pick     = sum[OW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    rr_nx       = rr_ptr;
    k_nx        = k;
    fail_nx     = 1'b0;
    set_early   = 1'b0;
    set_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        k_nx = '0;
        if (pick_vld) begin
          owner_nx = pick;
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        k_nx     = K_ONE;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        k_nx = k + K_ONE;
        // dn outranks both the timeout and a cancel in the same cycle.
        if (dn) begin
          state_nx = S_DONE;
          if (k <= K_LAST_EARLY) begin
            fail_nx   = 1'b1;
            set_early = 1'b1;
          end
        end else if (k == K_TIMEOUT) begin
          state_nx    = S_DONE;
          fail_nx     = 1'b1;
          set_timeout = 1'b1;
        end else if (!req[owner]) begin
          state_nx = S_IDLE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        rr_nx    = (owner == OWN_MAX) ? '0 : owner + OWN_ONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      k           <= '0;
      gnt         <= '0;
      done        <= '0;
      fail        <= 1'b0;
      ld          <= 1'b0;
      busy        <= 1'b0;
      err_early   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      owner       <= owner_nx;
      rr_ptr      <= rr_nx;
      k           <= k_nx;
      gnt         <= (state_nx != S_IDLE) ? (ONE_N << owner_nx) : '0;
      done        <= (state_nx == S_DONE) ? (ONE_N << owner_nx) : '0;
      fail        <= (state_nx == S_DONE) && fail_nx;
      ld          <= (state_nx == S_LOAD);
      busy        <= (state_nx != S_IDLE);
      err_early   <= err_early | set_early;
      err_timeout <= err_timeout | set_timeout;
    end
  end

endmodule
